// File: rtl/ac_key_conditioner_if.sv
// Key-conditioner pins: raw active-low buttons in, fan-mode level / speed-step pulse / held flag out.
interface ac_key_conditioner_if;
    logic key_mode_n;
    logic key_up_n;
    logic mode_en;
    logic up_pulse;
    logic up_held;

    modport master (
        output key_mode_n,
        output key_up_n,
        input  mode_en,
        input  up_pulse,
        input  up_held
    );

    modport slave (
        input  key_mode_n,
        input  key_up_n,
        output mode_en,
        output up_pulse,
        output up_held
    );
endinterface

// File: rtl/ac_key_conditioner.sv
// Sync + debounce of mode/speed-up buttons; mode toggle level and speed-up pulse with auto-repeat.
// Latency: key clean to output = DB_CYCLES+3 clk; no backpressure, outputs are free-running levels/pulses.
module ac_key_conditioner #(
    parameter int DB_CYCLES    = 1_000_000,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ac_key_conditioner_if.slave    kif
);

    localparam int TMAX = (DB_CYCLES > REPEAT_DELAY)
                        ? ((DB_CYCLES > REPEAT_RATE) ? DB_CYCLES : REPEAT_RATE)
                        : ((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam int TW = $clog2(TMAX) + 1;

    localparam logic [TW-1:0] DB_LAST = TW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RR_LAST = TW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } state_t;

    // bit 0 = mode key, bit 1 = speed-up key; all active-low
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    stable_d;
    logic [TW-1:0] db_cnt [2];

    logic          mode_press;
    logic          up_press;
    logic          up_down;
    logic          mode_en_q;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          pulse_nxt;
    logic          up_pulse_q;

    assign raw = {kif.key_up_n, kif.key_mode_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '1;
            sync2     <= '1;
            stable    <= '1;
            stable_d  <= '1;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + TW'(1);
                end
            end
        end
    end

    assign mode_press = stable_d[0] & ~stable[0];
    assign up_press   = stable_d[1] & ~stable[1];
    assign up_down    = ~stable[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_en_q <= 1'b0;
        end else if (mode_press) begin
            mode_en_q <= ~mode_en_q;
        end
    end

    // Gating uses the registered mode_en, so a same-cycle mode press does not affect this cycle
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        pulse_nxt = 1'b0;
        if (!mode_en_q) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (up_press) begin
                        pulse_nxt = 1'b1;
                        state_nxt = S_DELAY;
                        timer_nxt = '0;
                    end
                end
                S_DELAY: begin
                    if (!up_down) begin
                        state_nxt = S_IDLE;
                        timer_nxt = '0;
                    end else if (timer == RD_LAST) begin
                        pulse_nxt = 1'b1;
                        state_nxt = S_REPEAT;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                S_REPEAT: begin
                    if (!up_down) begin
                        state_nxt = S_IDLE;
                        timer_nxt = '0;
                    end else if (timer == RR_LAST) begin
                        pulse_nxt = 1'b1;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            up_pulse_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            up_pulse_q <= pulse_nxt;
        end
    end

    assign kif.mode_en  = mode_en_q;
    assign kif.up_pulse = up_pulse_q;
    assign kif.up_held  = up_down & mode_en_q;

endmodule
